// File: rtl/uart_tx_sequencer.sv
// Control FSM for the UART transmit path: loads an external shift register bank,
// shifts it once per bit time and frames the serial line with start/stop bits.
module uart_tx_sequencer #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int DATA_BITS     = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SEND,
  input  logic SDATA,
  output logic LOAD,
  output logic SHIFT,
  output logic TX,
  output logic BUSY,
  output logic SENT
);

  localparam int BAUD_PERIOD = CLK_FREQUENCY / BAUD_RATE;
  localparam int TW = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(BAUD_PERIOD - 1);
  localparam logic [CW-1:0] BIT_MAX   = CW'(DATA_BITS - 1);

  if (BAUD_PERIOD < 2) begin : g_bad_baud
    $error("uart_tx_sequencer: BAUD_PERIOD must be at least 2 cycles");
  end
  if (DATA_BITS < 1 || DATA_BITS > 16) begin : g_bad_bits
    $error("uart_tx_sequencer: DATA_BITS must be in 1..16");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BITS,
    S_STOP,
    S_ACK
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [CW-1:0]   r_bitcnt;
  logic            w_tc;

  assign w_tc = (r_timer == TIMER_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_timer  <= '0;
          r_bitcnt <= '0;
          if (SEND) r_state <= S_START;
        end
        S_START: begin
          if (w_tc) begin
            r_timer <= '0;
            r_state <= S_BITS;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_BITS: begin
          if (w_tc) begin
            r_timer <= '0;
            if (r_bitcnt == BIT_MAX) begin
              r_bitcnt <= '0;
              r_state  <= S_STOP;
            end else begin
              r_bitcnt <= r_bitcnt + CW'(1);
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_STOP: begin
          if (w_tc) begin
            r_timer <= '0;
            r_state <= S_ACK;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_ACK: begin
          if (!SEND) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line outputs decode only from registered state and the bank's registered LSB;
  // reset drives the state to IDLE asynchronously, so TX goes high without a clock.
  always_comb begin
    // NOTE: every output gets a default first so no branch can infer a latch.
    TX    = 1'b1;
    BUSY  = 1'b0;
    SENT  = 1'b0;
    LOAD  = 1'b0;
    SHIFT = 1'b0;
    unique case (r_state)
      S_IDLE:  LOAD = SEND;
      S_START: begin
        TX   = 1'b0;
        BUSY = 1'b1;
      end
      S_BITS: begin
        TX    = SDATA;
        BUSY  = 1'b1;
        SHIFT = w_tc;
      end
      S_STOP:  BUSY = 1'b1;
      S_ACK:   SENT = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: models the external shift register
// bank and scores the TX line per cycle against a queue of expected bits.
module tb_uart_tx_sequencer;

  localparam int P  = 4;
  localparam int NB = 8;
  localparam int P2 = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic send, send2;
  logic load, shift, tx, busy, sent, sdata;
  logic load2, shift2, tx2, busy2, sent2, sdata2;

  logic [7:0] bank_data = 8'h00;
  logic [7:0] sr = 8'h00;
  logic       bank2_data = 1'b0;
  logic       sr2 = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_sequencer #(.CLK_FREQUENCY(16), .BAUD_RATE(4), .DATA_BITS(NB)) dut (
    .CLK(clk), .RST_N(rst_n), .SEND(send), .SDATA(sdata),
    .LOAD(load), .SHIFT(shift), .TX(tx), .BUSY(busy), .SENT(sent)
  );

  uart_tx_sequencer #(.CLK_FREQUENCY(4), .BAUD_RATE(2), .DATA_BITS(1)) dut_corner (
    .CLK(clk), .RST_N(rst_n), .SEND(send2), .SDATA(sdata2),
    .LOAD(load2), .SHIFT(shift2), .TX(tx2), .BUSY(busy2), .SENT(sent2)
  );

  // External parallel-load / shift-right banks.
  always @(posedge clk) begin
    if (load)       sr <= bank_data;
    else if (shift) sr <= sr >> 1;
    if (load2)       sr2 <= bank2_data;
    else if (shift2) sr2 <= 1'b0;
  end
  assign sdata  = sr[0];
  assign sdata2 = sr2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_tx"}, tx, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sent"}, sent, 0);
    check({tag, "_load"}, load, 0);
  endtask

  // Called at the start of cycle 0; returns at the negedge of the last ACK cycle.
  task automatic send_frame(input logic [7:0] d, input int drop_cyc, input int hold);
    int n_shift = 0;
    int n_load  = 0;
    logic e;
    logic b;
    for (int k = 0; k < NB + 2; k++) begin
      b = (k == 0) ? 1'b0 : (k == NB + 1) ? 1'b1 : d[k-1];
      for (int j = 0; j < P; j++) exp_q.push_back(b);
    end
    bank_data = d;
    send = 1'b1;
    @(negedge clk);
    check("c0_load", load, 1);
    check("c0_tx", tx, 1);
    check("c0_busy", busy, 0);
    for (int c = 1; c <= (NB + 2) * P; c++) begin
      tick();
      if (c == drop_cyc) send = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("tx_c%0d", c), tx, e);
      check($sformatf("busy_c%0d", c), busy, 1);
      check($sformatf("shift_c%0d", c), shift,
            (c % P == 0 && c >= 2 * P && c <= (NB + 1) * P) ? 1 : 0);
      if (shift) n_shift++;
      if (load)  n_load++;
    end
    check("shift_count", n_shift, NB);
    check("load_count", n_load, 0);
    tick();
    @(negedge clk);
    check("sent_rise", sent, 1);
    check("sent_busy", busy, 0);
    check("sent_tx", tx, 1);
    check("sent_load", load, 0);
    if (send) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        @(negedge clk);
        check("hold_sent", sent, 1);
        check("hold_tx", tx, 1);
        check("hold_load", load, 0);
      end
      tick();
      send = 1'b0;
      @(negedge clk);
      check("drop_sent", sent, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_shift2;
    logic e;
    rst_n = 1'b0;
    send  = 1'b0;
    send2 = 1'b0;
    #3;
    check("rst_tx", tx, 1);
    check("rst_load", load, 0);
    check("rst_shift", shift, 0);
    check("rst_busy", busy, 0);
    check("rst_sent", sent, 0);
    check("rst_tx2", tx2, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    idle_check("idle0");

    // Basic frame.
    tick();
    send_frame(8'hA5, -1, 0);
    tick();
    idle_check("idle_basic");

    // Handshake hold for 20 cycles after SENT.
    tick();
    send_frame(8'hA5, -1, 20);
    tick();
    idle_check("idle_hold");

    // SEND released mid-frame.
    tick();
    send_frame(8'hA5, 10, 0);
    tick();
    idle_check("idle_drop");

    // Async reset during data bit 3 (cycles 17..20).
    tick();
    bank_data = 8'hA5;
    send = 1'b1;
    @(negedge clk);
    check("ar_load", load, 1);
    repeat (18) @(posedge clk);
    @(negedge clk);
    check("ar_bit3_tx", tx, 0);
    check("ar_bit3_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_tx", tx, 1);
    check("ar_busy", busy, 0);
    check("ar_sent", sent, 0);
    check("ar_shift", shift, 0);
    tick();
    rst_n = 1'b1;
    send_frame(8'h3C, -1, 0);
    tick();
    idle_check("idle_reset");

    // Back-to-back frames, SEND low for one cycle between them.
    tick();
    send_frame(8'h00, -1, 0);
    tick();
    send_frame(8'hFF, -1, 0);
    tick();
    idle_check("idle_b2b");

    // Parameter corner: DATA_BITS=1, P=2, data=1.
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < P2; j++) exp_q.push_back(k == 0 ? 1'b0 : 1'b1);
    n_shift2 = 0;
    tick();
    bank2_data = 1'b1;
    send2 = 1'b1;
    @(negedge clk);
    check("cn_load", load2, 1);
    for (int c = 1; c <= 3 * P2; c++) begin
      tick();
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("cn_tx_c%0d", c), tx2, e);
      check($sformatf("cn_busy_c%0d", c), busy2, 1);
      if (shift2) n_shift2++;
    end
    check("cn_shift_count", n_shift2, 1);
    tick();
    @(negedge clk);
    check("cn_sent_c7", sent2, 1);
    check("cn_busy_c7", busy2, 0);
    tick();
    send2 = 1'b0;
    @(negedge clk);
    check("cn_sent_hold", sent2, 1);
    tick();
    @(negedge clk);
    check("cn_sent_idle", sent2, 0);
    check("cn_tx_idle", tx2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

Control FSM for the UART transmit datapath. It sequences an external parallel-load/shift register bank built from 1-bit load registers: it loads the bank, shifts it once per bit time, and drives the serial TX line with start, data and stop bits. It sits between the host-side SEND/SENT handshake and the transmit shift register bank, which feeds its LSB back as SDATA.

## Interface
- CLK_FREQUENCY, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 19_200: serial bit rate in Hz.
- DATA_BITS, 8: data bits per frame, range 1..16.
- Derived BAUD_PERIOD = CLK_FREQUENCY / BAUD_RATE (integer division), in cycles per bit.
  - Must be ≥ 2; elaborate with $error otherwise.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- SEND  input  1  level request to transmit one frame.
- SDATA  input  1  current LSB of the external shift register bank.
- LOAD  output  1  one-cycle strobe; the bank captures parallel data on the same edge.
- SHIFT  output  1  one-cycle strobe; the bank shifts right by one on the same edge.
- TX  output  1  serial line; idle high.
- BUSY  output  1  high while a frame is on the line.
- SENT  output  1  frame-complete acknowledge.

## Operation
- States: IDLE, START, BITS, STOP, ACK. All are registered and share one timer (0..BAUD_PERIOD-1) and one bit counter (0..DATA_BITS-1).
- IDLE: timer and bit counter are held at 0.
  - When SEND=1: LOAD=1 for this cycle (Mealy) and the next state is START.
- START: TX=0.
  - At timer terminal count (timer==BAUD_PERIOD-1) the timer clears and the next state is BITS.
- BITS: TX=SDATA.
  - At each terminal count SHIFT=1 for that cycle (including the last bit) and the timer clears.
  - If bitcnt==DATA_BITS-1: bitcnt clears and the next state is STOP.
  - Otherwise bitcnt increments.
- STOP: TX=1.
  - At terminal count the timer clears and the next state is ACK.
- ACK: TX=1, SENT=1.
  - Stays in ACK while SEND=1.
  - SEND=0 moves to IDLE.
- BUSY=1 exactly in START, BITS and STOP.
- TX, BUSY and SENT decode from registered state and the external SDATA register only, so they are glitch-free.
- LOAD is asserted only in IDLE. SHIFT is asserted only in BITS. The two are never high together.
- SEND is ignored in START, BITS and STOP. Dropping SEND mid-frame does not abort the frame.
- Reset: state=IDLE, timer=0, bitcnt=0.
  - Reset values: TX=1, LOAD=0, SHIFT=0, BUSY=0, SENT=0.
  - Reset asserted mid-frame forces TX=1 immediately, with no clock needed.
  - If SEND is still 1 when RST_N releases, a fresh frame starts (LOAD pulse) on the first clock.

## Timing
- Cycle 0 is the IDLE cycle with SEND=1 (LOAD=1). TX falls to 0 in cycle 1.
- START occupies cycles 1..P, where P=BAUD_PERIOD.
- Data bit k occupies cycles 1+(k+1)P .. (k+2)P. Its SHIFT strobe is in the last cycle of that window.
- STOP occupies cycles 1+(DATA_BITS+1)P .. (DATA_BITS+2)P.
- SENT rises in cycle 1+(DATA_BITS+2)P, which is 10P+1 for 8 bits.
- SENT falls in the first cycle after SEND is sampled 0. IDLE is re-entered the same edge.
  - A new frame needs SEND to return to 1, so there is a minimum of 1 idle cycle between frames.
- Frame length on the line is exactly (DATA_BITS+2)·P cycles.
- Strobe counts per frame: exactly one LOAD and exactly DATA_BITS SHIFT.

## Test plan
- Bench setup: CLK_FREQUENCY=16, BAUD_RATE=4 (P=4), DATA_BITS=8. The bench models the 8-bit shift register, loaded with 0xA5.
- Basic frame:
  - Stimulus: SEND=1 at cycle 0.
  - Required: LOAD only at cycle 0; TX = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
  - Required: SENT=1 at cycle 41; exactly 8 SHIFT pulses.
- Handshake hold:
  - Stimulus: keep SEND=1 for 20 cycles after SENT rises, then drop it.
  - Required: SENT stays 1 and TX stays 1 throughout; IDLE is entered 1 cycle after the drop; no second LOAD occurs.
- Mid-frame SEND drop:
  - Stimulus: release SEND at cycle 10.
  - Required: the frame completes unchanged; SENT pulses for 1 cycle at cycle 41 and then IDLE.
- Async reset mid-frame:
  - Stimulus: pull RST_N low between clock edges during data bit 3.
  - Required: TX=1, BUSY=0 and SENT=0 before the next edge.
  - Required: after release with SEND=1, LOAD pulses on the first clock and a full frame follows.
- Back-to-back frames:
  - Stimulus: frames of 0x00 then 0xFF, with SEND toggled low for 1 cycle between them.
  - Required: TX shows 0/00000000/1 then 0/11111111/1; each frame is exactly 40 cycles; BUSY=0 only between the frames.
- Parameter corner:
  - Stimulus: DATA_BITS=1, P=2, data=1.
  - Required: TX sequence 0,0,1,1,1,1; SENT at cycle 7; one SHIFT pulse.
